// File: rtl/axi_stream_write_fifo_if.sv
// AXI-Stream master bundle driven by the transmit FIFO.
// The master modport drives payload and TVALID; the slave modport drives TREADY.
interface axi_stream_write_fifo_if #(
    parameter int BUS_WIDTH  = 64,
    parameter int DEST_WIDTH = 8,
    parameter int ID_WIDTH   = 8
) ();
    logic                    tvalid;
    logic                    tready;
    logic [BUS_WIDTH-1:0]    tdata;
    logic [BUS_WIDTH/8-1:0]  tkeep;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [ID_WIDTH-1:0]     tid;
    logic                    tlast;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tdest,
        output tid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tdest,
        input  tid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axi_stream_write_fifo.sv
// Buffered AXI-Stream transmitter.
// A DEPTH-entry circular buffer of beats (data/keep/last/dest/id) that accepts one
// beat per clock from the packetiser and presents the head entry on the AXIS bus.
// The payload is always driven from storage registers, so there is no path from the
// push inputs to the bus; a beat pushed into an empty FIFO appears one cycle later.
// Status outputs (ready/idle/count/valid) are registered from the next-count value.
module axi_stream_write_fifo #(
    parameter int BUS_WIDTH  = 64,
    parameter int DEPTH      = 4,
    parameter int DEST_WIDTH = 8,
    parameter int ID_WIDTH   = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_aresetn,

    input  logic                       i_enable,
    output logic                       o_ready,
    output logic                       o_idle,
    output logic [$clog2(DEPTH):0]     o_count,
    input  logic [BUS_WIDTH-1:0]       i_data_to_transmit,
    input  logic [BUS_WIDTH/8-1:0]     i_tkeep,
    input  logic                       i_tlast,
    input  logic [DEST_WIDTH-1:0]      i_tdest,
    input  logic [ID_WIDTH-1:0]        i_tid,

    output logic                       o_overflow,
    output logic [CNT_WIDTH-1:0]       o_pkt_count,

    axi_stream_write_fifo_if.master    m_axis
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int KW = BUS_WIDTH / 8;

    // Beat storage, one array per field.
    logic [BUS_WIDTH-1:0]  r_mem_data [DEPTH];
    logic [KW-1:0]         r_mem_keep [DEPTH];
    logic                  r_mem_last [DEPTH];
    logic [DEST_WIDTH-1:0] r_mem_dest [DEPTH];
    logic [ID_WIDTH-1:0]   r_mem_id   [DEPTH];

    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic                  r_ready;
    logic                  r_idle;
    logic                  r_tvalid;
    logic                  r_overflow;
    logic [CNT_WIDTH-1:0]  r_pkt_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_head_last;
    logic [CW-1:0]         w_count_next;

    // Handshake qualification. Push depends only on the registered ready, so a
    // pop in the same cycle never frees a slot for a push while full.
    always_comb begin
        w_push      = i_enable && r_ready;
        w_drop      = i_enable && !r_ready;
        w_pop       = r_tvalid && m_axis.tready;
        w_head_last = r_mem_last[r_rd_ptr];
    end

    // Occupancy next-state: push and pop together leave the count unchanged.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Beat storage write; entries are cleared on reset so the idle payload is zero.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_keep[i] <= '0;
                r_mem_last[i] <= 1'b0;
                r_mem_dest[i] <= '0;
                r_mem_id[i]   <= '0;
            end
        end else if (w_push) begin
            r_mem_data[r_wr_ptr] <= i_data_to_transmit;
            r_mem_keep[r_wr_ptr] <= i_tkeep;
            r_mem_last[r_wr_ptr] <= i_tlast;
            r_mem_dest[r_wr_ptr] <= i_tdest;
            r_mem_id[r_wr_ptr]   <= i_tid;
        end
    end

    // Read/write pointers; DEPTH is a power of two so they wrap naturally.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy and registered status derived from the next count.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_count  <= '0;
            r_ready  <= 1'b1;
            r_idle   <= 1'b1;
            r_tvalid <= 1'b0;
        end else begin
            r_count  <= w_count_next;
            r_ready  <= (w_count_next != CW'(DEPTH));
            r_idle   <= (w_count_next == '0);
            r_tvalid <= (w_count_next != '0);
        end
    end

    // Sticky overflow: any push attempt while full, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Transmitted-packet counter: counts TLAST beats accepted by the fabric, wrapping.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_pkt_count <= '0;
        end else if (w_pop && w_head_last) begin
            r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
        end
    end

    // Outputs: payload is the head entry, selected by the registered read pointer.
    always_comb begin
        m_axis.tvalid = r_tvalid;
        m_axis.tdata  = r_mem_data[r_rd_ptr];
        m_axis.tkeep  = r_mem_keep[r_rd_ptr];
        m_axis.tlast  = r_mem_last[r_rd_ptr];
        m_axis.tdest  = r_mem_dest[r_rd_ptr];
        m_axis.tid    = r_mem_id[r_rd_ptr];
        o_ready       = r_ready;
        o_idle        = r_idle;
        o_count       = r_count;
        o_overflow    = r_overflow;
        o_pkt_count   = r_pkt_count;
    end

endmodule
